regfile_2r1w: RTL
=================

REGFILE_2R1W -- requirements
Module: regfile_2r1w

Interface
REQ-001 Parameter WIDTH SHALL be: WIDTH, default 16, data word width in bits.
REQ-002 Parameter DEPTH SHALL be: DEPTH, default 8, number of registers (2..256).
REQ-003 Parameter AW SHALL be: AW, default $clog2(DEPTH), index width; it is derived and not overridden.
REQ-004 Port clk SHALL be: clk  in  1  sole clock, rising edge.
REQ-005 Port reset SHALL be: reset  in  1  synchronous, active-high reset.
REQ-006 Port data_in SHALL be: data_in  in  WIDTH  write data.
REQ-007 Port writenum SHALL be: writenum  in  AW  write index.
REQ-008 Port write SHALL be: write  in  1  write enable.
REQ-009 Port readnum_a SHALL be: readnum_a  in  AW  read index, port A.
REQ-010 Port readnum_b SHALL be: readnum_b  in  AW  read index, port B.
REQ-011 Port data_out_a SHALL be: data_out_a  out  WIDTH  read data, port A, combinational.
REQ-012 Port data_out_b SHALL be: data_out_b  out  WIDTH  read data, port B, combinational.
REQ-013 Port clear SHALL be: clear  in  1  single-cycle request to zero all registers.
REQ-014 Port busy SHALL be: busy  out  1  registered; high while a clear sweep runs.
REQ-015 Port write_drop SHALL be: write_drop  out  1  registered, one-cycle pulse when a write is discarded.

Function
REQ-016 A write with write=1 and writenum<DEPTH in state IDLE SHALL update R[writenum] at the next rising edge.
REQ-017 Written data SHALL be visible on the read ports from the cycle after that edge.
REQ-018 A read with readnum<DEPTH SHALL return R[readnum] combinationally; readnum>=DEPTH SHALL return all zeros.
REQ-019 Both read ports SHALL be independent, and the same index on both ports SHALL return identical data.
REQ-020 A write with writenum>=DEPTH SHALL leave all registers unchanged and SHALL pulse write_drop for one cycle.
REQ-021 The FSM SHALL have exactly two states, IDLE and CLEAR, and busy SHALL equal (state==CLEAR).
REQ-022 In IDLE, clear=1 sampled at edge k SHALL move the FSM to CLEAR and load the sweep pointer with 0.
REQ-023 In CLEAR, each edge SHALL write 0 to R[ptr] and then increment ptr.
REQ-024 In CLEAR, the edge that zeroes R[DEPTH-1] SHALL return the FSM to IDLE.
REQ-025 For a clear sampled at edge k, busy SHALL be high for exactly DEPTH cycles and R[i] SHALL be zero after edge k+1+i.
REQ-026 When clear and write are both asserted in IDLE, clear SHALL take priority; the write SHALL be discarded and write_drop SHALL pulse.
REQ-027 Any write while busy=1 SHALL be discarded and SHALL pulse write_drop.
REQ-028 clear asserted while busy=1 SHALL be ignored, and the sweep SHALL not restart.
REQ-029 Reads during a sweep SHALL return current contents: zero for registers already swept, old data for the rest.

Reset
REQ-030 reset=1 at an edge SHALL zero all registers, force IDLE, and zero the pointer, busy and write_drop.
REQ-031 reset SHALL override write and clear in the same cycle.
REQ-032 reset asserted mid-sweep SHALL abort the sweep, and all registers SHALL be zero after that edge.

Configuration
REQ-033 Macro REGFILE_BYPASS_EN, when defined, SHALL enable write-through: an accepted write (REQ-016) whose writenum matches a readnum SHALL drive data_in onto that read port in the same cycle.
REQ-034 Without REGFILE_BYPASS_EN, the read ports SHALL return the pre-write value during the write cycle.
REQ-035 Discarded writes SHALL never be bypassed in either configuration.

Structure
REQ-036 Package regfile_pkg SHALL hold the state enum (IDLE, CLEAR) and the default WIDTH/DEPTH constants.
REQ-037 The sweep FSM, pointer, busy and write_drop logic SHALL be sub-module regfile_clear_seq, which outputs a clear-write strobe and index to the storage.

Verification
REQ-038 The bench SHALL cover: reset; write R3=16'hBEEF; next cycle readnum_a=3, readnum_b=3 -> both outputs 16'hBEEF.
REQ-039 The bench SHALL cover: write R7=16'h1234 and read R7 in the same cycle -> 16'h1234 with REGFILE_BYPASS_EN, old value 16'h0000 without it.
REQ-040 The bench SHALL cover: DEPTH=6, write writenum=6 -> no register changes, write_drop high for 1 cycle; readnum=7 -> 0.
REQ-041 The bench SHALL cover: fill R0..R7 with 16'hAAAA, pulse clear -> busy high exactly 8 cycles, R0 zero after cycle 1, R7 zero after cycle 8, reads of R7 during cycle 4 -> 16'hAAAA.
REQ-042 The bench SHALL cover: clear and write R2=16'h5555 in the same cycle -> R2 swept to 0, write_drop pulses; a second clear at busy cycle 3 does not extend busy beyond 8 cycles.
REQ-043 The bench SHALL cover: reset at busy cycle 4 -> busy=0 the next cycle, all registers 0, and a write accepted on the following cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared state enum and default sizing for the 2R1W register file
package regfile_pkg;
  typedef enum logic {IDLE, CLEAR} state_t;
  localparam int WIDTH_DEF = 16;
  localparam int DEPTH_DEF = 8;
endpackage

// File: rtl/regfile_clear_seq.sv
// regfile_clear_seq: clear-sweep FSM, sweep pointer, write acceptance and drop pulse
module regfile_clear_seq import regfile_pkg::*; #(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          write,
  input  logic [AW-1:0] writenum,
  output logic          busy,
  output logic          write_drop,
  output logic          accept,
  output logic          clr_we,
  output logic [AW-1:0] clr_idx
);
  state_t state, state_nxt;
  logic [AW-1:0] ptr, ptr_nxt;
  logic drop_nxt;
  // next state, pointer and write acceptance; a write is only taken in IDLE with no competing clear
  always_comb begin
    state_nxt = state == IDLE ? (clear ? CLEAR : IDLE) : (32'(ptr) == DEPTH - 1 ? IDLE : CLEAR);
    ptr_nxt = state == CLEAR ? ptr + AW'(1) : '0;
    accept = write && state == IDLE && !clear && 32'(writenum) < DEPTH;
    drop_nxt = write && !accept;
  end
  // state register, sweep pointer and one-cycle drop pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr <= '0;
      write_drop <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr <= ptr_nxt;
      write_drop <= drop_nxt;
    end
  end
  assign busy = state == CLEAR;
  assign clr_we = state == CLEAR;
  assign clr_idx = ptr;
endmodule

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: two-read one-write register file with sweep clear; REGFILE_BYPASS_EN enables write-through
module regfile_2r1w import regfile_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AW-1:0]    writenum,
  input  logic             write,
  input  logic [AW-1:0]    readnum_a,
  input  logic [AW-1:0]    readnum_b,
  output logic [WIDTH-1:0] data_out_a,
  output logic [WIDTH-1:0] data_out_b,
  input  logic             clear,
  output logic             busy,
  output logic             write_drop
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic accept, clr_we;
  logic [AW-1:0] clr_idx;
  logic [WIDTH-1:0] rd_a, rd_b;
  regfile_clear_seq #(.DEPTH(DEPTH), .AW(AW)) u_seq (
    .clk(clk),
    .reset(reset),
    .clear(clear),
    .write(write),
    .writenum(writenum),
    .busy(busy),
    .write_drop(write_drop),
    .accept(accept),
    .clr_we(clr_we),
    .clr_idx(clr_idx)
  );
  // storage: reset zeroes everything, the sweep zeroes one entry per cycle, otherwise accepted writes land
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr_we) begin
      mem[clr_idx] <= '0;
    end else if (accept) begin
      mem[writenum] <= data_in;
    end
  end
  // combinational reads; out-of-range indices read as zero, optional write-through of accepted writes
  always_comb begin
    rd_a = 32'(readnum_a) < DEPTH ? mem[readnum_a] : '0;
    rd_b = 32'(readnum_b) < DEPTH ? mem[readnum_b] : '0;
`ifdef REGFILE_BYPASS_EN
    data_out_a = accept && writenum == readnum_a ? data_in : rd_a;
    data_out_b = accept && writenum == readnum_b ? data_in : rd_b;
`else
    data_out_a = rd_a;
    data_out_b = rd_b;
`endif
  end
endmodule
